// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select generator and load-use / branch hazard control.
// Ports:
//   clk, rst_n            clock and async active-low reset
//   id_*                  decoded ID-stage instruction fields
//   branch_taken          EX resolved a taken branch/jump (flush request)
//   cnt_clr               synchronous clear of both performance counters
//   ForwardA, ForwardB    registered EX operand selects:
//                         2'b00 from_Reg, 2'b10 from_ex_mem, 2'b01 from_mem_wb
//   pc_write, if_id_write front-end hold controls (low during a load-use stall)
//   if_id_flush           IF/ID loads a NOP
//   id_ex_bubble          ID/EX loads a bubble
//   stall_count           saturating count of load-use stall cycles
//   flush_count           saturating count of flush cycles

module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              branch_taken,
    input  logic              cnt_clr,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Shadow destination metadata for EX, MEM and WB.
    logic              ex_valid_q, ex_valid_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              ex_wr_q, ex_wr_d;
    logic              ex_load_q, ex_load_d;

    logic              mem_valid_q, mem_valid_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_load_q, mem_load_d;

    logic              wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic              wb_wr_q, wb_wr_d;
    logic              wb_load_q, wb_load_d;

    logic [1:0]        fwd_a_q, fwd_a_d;
    logic [1:0]        fwd_b_q, fwd_b_d;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              stall;
    logic              flush;
    logic              bubble;
    logic              load_hit_rs1;
    logic              load_hit_rs2;

    // WB metadata is tracked for completeness of the shadow pipeline;
    // forwarding only needs EX and MEM, so nothing reads it here.
    logic              wb_unused;
    assign wb_unused = ^{wb_valid_q, wb_rd_q, wb_wr_q, wb_load_q,
                         mem_load_q};

    function automatic logic stage_match(
        input logic              v,
        input logic              wr,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] r
    );
        return v & wr & (rd != '0) & (rd == r);
    endfunction

    function automatic logic [1:0] fwd_select(
        input logic              kill,
        input logic              use_r,
        input logic [REG_AW-1:0] r,
        input logic              exv,
        input logic              exw,
        input logic [REG_AW-1:0] exd,
        input logic              mmv,
        input logic              mmw,
        input logic [REG_AW-1:0] mmd
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (kill || !use_r) begin
            sel = FWD_REG;
        end else if (stage_match(exv, exw, exd, r)) begin
            sel = FWD_EX_MEM;
        end else if (stage_match(mmv, mmw, mmd, r)) begin
            sel = FWD_MEM_WB;
        end
        return sel;
    endfunction

    // Hazard detection and front-end control.
    always_comb begin
        load_hit_rs1 = ex_valid_q & ex_load_q & (ex_rd_q != '0) &
                       id_uses_rs1 & (id_rs1 == ex_rd_q);
        load_hit_rs2 = ex_valid_q & ex_load_q & (ex_rd_q != '0) &
                       id_uses_rs2 & (id_rs2 == ex_rd_q);
        stall        = id_valid & (load_hit_rs1 | load_hit_rs2);
        flush        = branch_taken;
        bubble       = stall | flush;
        pc_write     = ~(stall & ~flush);
        if_id_write  = ~(stall & ~flush);
        if_id_flush  = flush;
        id_ex_bubble = bubble;
    end

    // Shadow pipeline advance; an invalid ID slot enters EX as a bubble.
    always_comb begin
        ex_valid_d  = id_valid & ~bubble;
        ex_rd_d     = id_rd;
        ex_wr_d     = id_reg_write;
        ex_load_d   = id_is_load;

        mem_valid_d = ex_valid_q;
        mem_rd_d    = ex_rd_q;
        mem_wr_d    = ex_wr_q;
        mem_load_d  = ex_load_q;

        wb_valid_d  = mem_valid_q;
        wb_rd_d     = mem_rd_q;
        wb_wr_d     = mem_wr_q;
        wb_load_d   = mem_load_q;
    end

    // Selects for the instruction about to enter EX. A load in EX that
    // matches always stalls, so it never reaches the EX-match branch here.
    always_comb begin
        fwd_a_d = fwd_select(bubble | ~id_valid, id_uses_rs1, id_rs1,
                             ex_valid_q, ex_wr_q, ex_rd_q,
                             mem_valid_q, mem_wr_q, mem_rd_q);
        fwd_b_d = fwd_select(bubble | ~id_valid, id_uses_rs2, id_rs2,
                             ex_valid_q, ex_wr_q, ex_rd_q,
                             mem_valid_q, mem_wr_q, mem_rd_q);
    end

    // Saturating counters; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && !flush && stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush && flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_wr_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_wr_q    <= 1'b0;
            mem_load_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_wr_q     <= 1'b0;
            wb_load_q   <= 1'b0;
            fwd_a_q     <= FWD_REG;
            fwd_b_q     <= FWD_REG;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_wr_q     <= ex_wr_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_load_q  <= mem_load_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_wr_q     <= wb_wr_d;
            wb_load_q   <= wb_load_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ForwardA    = fwd_a_q;
    assign ForwardB    = fwd_b_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed hazard sequences,
// counter saturation/clear, mid-stream reset and random instruction streams.

module tb_fwd_hazard_unit;

    localparam int TB_CNT_W = 12;
    localparam int CMAX     = (1 << TB_CNT_W) - 1;

    localparam logic [1:0] F_REG = 2'b00;
    localparam logic [1:0] F_MW  = 2'b01;
    localparam logic [1:0] F_EM  = 2'b10;

    typedef struct {
        bit       v;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
    } instr_t;

    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } prod_t;

    typedef struct {
        bit [1:0] fa;
        bit [1:0] fb;
        bit       pcw;
        bit       ifw;
        bit       ifl;
        bit       bub;
        int       sc;
        int       fc;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                id_valid;
    logic [4:0]          id_rs1;
    logic [4:0]          id_rs2;
    logic                id_uses_rs1;
    logic                id_uses_rs2;
    logic [4:0]          id_rd;
    logic                id_reg_write;
    logic                id_is_load;
    logic                branch_taken;
    logic                cnt_clr;
    logic [1:0]          ForwardA;
    logic [1:0]          ForwardB;
    logic                pc_write;
    logic                if_id_write;
    logic                if_id_flush;
    logic                id_ex_bubble;
    logic [TB_CNT_W-1:0] stall_count;
    logic [TB_CNT_W-1:0] flush_count;

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .branch_taken(branch_taken),
        .cnt_clr(cnt_clr), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_chk;
    int    n_fail;
    int    cyc;
    exp_t  sbq[$];

    // Reference model: recent producers, newest first (index 0 is in EX).
    prod_t hist[$];
    bit [1:0] fa_m;
    bit [1:0] fb_m;
    int       sc_m;
    int       fc_m;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("ForwardA", 32'(ForwardA), 32'(e.fa));
                check("ForwardB", 32'(ForwardB), 32'(e.fb));
                check("pc_write", 32'(pc_write), 32'(e.pcw));
                check("if_id_write", 32'(if_id_write), 32'(e.ifw));
                check("if_id_flush", 32'(if_id_flush), 32'(e.ifl));
                check("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bub));
                check("stall_count", 32'(stall_count), e.sc);
                check("flush_count", 32'(flush_count), e.fc);
            end
        end
    end

    function automatic bit writes_reg(prod_t p, int r);
        return p.v && p.wr && p.rd != 0 && p.rd == r;
    endfunction

    function automatic bit [1:0] pick(bit kill, bit use_r, int r);
        if (kill || !use_r) return F_REG;
        if (writes_reg(hist[0], r)) return F_EM;
        if (writes_reg(hist[1], r)) return F_MW;
        return F_REG;
    endfunction

    task automatic model_reset();
        prod_t nop;
        nop = '{v: 0, rd: 0, wr: 0, ld: 0};
        hist.delete();
        repeat (3) hist.push_back(nop);
        fa_m = F_REG;
        fb_m = F_REG;
        sc_m = 0;
        fc_m = 0;
    endtask

    task automatic drive_cycle(input instr_t i, input bit br,
                               input bit clr, input bit rst,
                               output bit stalled);
        exp_t  e;
        prod_t p;
        bit    st;
        bit    bub;
        @(posedge clk);
        #1;
        rst_n        = !rst;
        id_valid     = i.v;
        id_rs1       = i.rs1;
        id_rs2       = i.rs2;
        id_uses_rs1  = i.u1;
        id_uses_rs2  = i.u2;
        id_rd        = i.rd;
        id_reg_write = i.wr;
        id_is_load   = i.ld;
        branch_taken = br;
        cnt_clr      = clr;
        if (rst) model_reset();
        st = i.v && hist[0].v && hist[0].ld && hist[0].rd != 0 &&
             ((i.u1 && int'(i.rs1) == hist[0].rd) ||
              (i.u2 && int'(i.rs2) == hist[0].rd));
        bub   = st || br;
        e.fa  = fa_m;
        e.fb  = fb_m;
        e.pcw = !(st && !br);
        e.ifw = !(st && !br);
        e.ifl = br;
        e.bub = bub;
        e.sc  = sc_m;
        e.fc  = fc_m;
        sbq.push_back(e);
        if (!rst) begin
            fa_m = pick(bub || !i.v, i.u1, int'(i.rs1));
            fb_m = pick(bub || !i.v, i.u2, int'(i.rs2));
            if (clr) begin
                sc_m = 0;
                fc_m = 0;
            end else begin
                if (st && !br && sc_m < CMAX) sc_m++;
                if (br && fc_m < CMAX) fc_m++;
            end
            p.v  = i.v && !bub;
            p.rd = int'(i.rd);
            p.wr = i.wr;
            p.ld = i.ld;
            hist.push_front(p);
            void'(hist.pop_back());
        end
        stalled = st && !br;
    endtask

    // Issue one instruction, holding it in ID for as long as it stalls.
    task automatic issue(input instr_t i, input bit br = 0,
                         input bit clr = 0);
        bit st;
        bit b;
        bit c;
        b = br;
        c = clr;
        do begin
            drive_cycle(i, b, c, 1'b0, st);
            b = 1'b0;
            c = 1'b0;
        end while (st);
    endtask

    task automatic do_reset(input int n);
        instr_t z;
        bit st;
        z = '{default: 0};
        repeat (n) drive_cycle(z, 1'b0, 1'b0, 1'b1, st);
    endtask

    function automatic instr_t mk(bit v, int rs1, int rs2, bit u1, bit u2,
                                  int rd, bit wr, bit ld);
        instr_t i;
        i.v   = v;
        i.rs1 = 5'(rs1);
        i.rs2 = 5'(rs2);
        i.u1  = u1;
        i.u2  = u2;
        i.rd  = 5'(rd);
        i.wr  = wr;
        i.ld  = ld;
        return i;
    endfunction

    instr_t nop_i;

    initial begin
        instr_t r;
        n_chk        = 0;
        n_fail       = 0;
        cyc          = 0;
        rst_n        = 1'b0;
        id_valid     = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_uses_rs1  = 1'b0;
        id_uses_rs2  = 1'b0;
        id_rd        = '0;
        id_reg_write = 1'b0;
        id_is_load   = 1'b0;
        branch_taken = 1'b0;
        cnt_clr      = 1'b0;
        nop_i        = mk(1, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        do_reset(2);

        // add x5 ; sub x6,x5,x7
        issue(mk(1, 1, 2, 1, 1, 5, 1, 0));
        issue(mk(1, 5, 7, 1, 1, 6, 1, 0));
        issue(nop_i);
        // add x5 ; nop ; or x8,x1,x5
        issue(mk(1, 1, 2, 1, 1, 5, 1, 0));
        issue(nop_i);
        issue(mk(1, 1, 5, 1, 1, 8, 1, 0));
        // add x5 ; add x5 ; or x9,x5,x5
        issue(mk(1, 1, 2, 1, 1, 5, 1, 0));
        issue(mk(1, 3, 4, 1, 1, 5, 1, 0));
        issue(mk(1, 5, 5, 1, 1, 9, 1, 0));
        // add x0 ; sub x1,x0,x0
        issue(mk(1, 1, 2, 1, 1, 0, 1, 0));
        issue(mk(1, 0, 0, 1, 1, 1, 1, 0));
        issue(nop_i);
        issue(nop_i);
        // lw x3 ; add x4,x3,x2
        issue(mk(1, 10, 0, 1, 0, 3, 1, 1));
        issue(mk(1, 3, 2, 1, 1, 4, 1, 0));
        issue(nop_i);
        // lw x3 ; add x4,x3,x2 with a taken branch in the same cycle
        issue(mk(1, 10, 0, 1, 0, 3, 1, 1));
        issue(mk(1, 3, 2, 1, 1, 4, 1, 0), 1'b1);
        issue(nop_i);
        // Back-to-back loads, each consumed
        issue(mk(1, 10, 0, 1, 0, 3, 1, 1));
        issue(mk(1, 3, 0, 1, 0, 7, 1, 1));
        issue(mk(1, 7, 7, 1, 1, 8, 1, 0));
        // Mid-stream reset with a pending producer
        issue(mk(1, 1, 2, 1, 1, 5, 1, 0));
        do_reset(2);
        issue(mk(1, 1, 5, 1, 1, 8, 1, 0));
        issue(mk(1, 5, 5, 1, 1, 9, 1, 0));
        // Saturate stall_count, then clear
        repeat (CMAX + 4) issue(mk(1, 3, 0, 1, 0, 3, 1, 1));
        issue(nop_i);
        issue(nop_i, 1'b0, 1'b1);
        issue(nop_i);
        // Random streams with small register set for dense hazards
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end
            r = mk($urandom_range(0, 7) != 0,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 7)),
                   $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
            issue(r, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end
        issue(nop_i);

        for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d exp=0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
